// File: rtl/sc_backg_controller_pkg.sv
// sc_backg_controller_pkg
// Shared definitions for the frogger background controller and the
// background register it commands: controller state encoding, game-stage
// (transition counter) constants and the shift-selection codes.
package sc_backg_controller_pkg;

  localparam int TC_W = 4;

  localparam logic [TC_W-1:0] TC_START = 4'd0;
  localparam logic [TC_W-1:0] TC_WIN   = 4'd9;

  typedef enum logic [2:0] {
    INIT,
    LOAD,
    START,
    TRANS,
    LEVEL,
    LOST,
    WON
  } state_e;

  typedef enum logic [1:0] {
    SHIFT_HOLD  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10
  } shift_e;

  // Advance to the next game stage, saturating at the win stage so the
  // stage counter can never leave the 0..9 range.
  function automatic logic [TC_W-1:0] next_stage(input logic [TC_W-1:0] tc);
    return (tc >= TC_WIN) ? TC_WIN : tc + 4'd1;
  endfunction

endpackage

// File: rtl/sc_backg_controller_if.sv
// sc_backg_controller_if
// Groups the controller's game-event inputs and background-register command
// outputs.
//   master : game logic / stimulus side (drives start, tick, levelup, lose)
//   slave  : the controller (drives clear, load, shiftselection, stage count)
interface sc_backg_controller_if;
  import sc_backg_controller_pkg::*;

  logic            SC_BACKG_CONTROLLER_start_InLow;
  logic            SC_BACKG_CONTROLLER_tick_In;
  logic            SC_BACKG_CONTROLLER_levelup_In;
  logic            SC_BACKG_CONTROLLER_lose_In;
  logic            SC_BACKG_CONTROLLER_clear_OutLow;
  logic            SC_BACKG_CONTROLLER_load_OutLow;
  logic [1:0]      SC_BACKG_CONTROLLER_shiftselection_Out;
  logic [TC_W-1:0] SC_BACKG_CONTROLLER_transitioncounter_OutBUS;

  modport master (
    output SC_BACKG_CONTROLLER_start_InLow,
    output SC_BACKG_CONTROLLER_tick_In,
    output SC_BACKG_CONTROLLER_levelup_In,
    output SC_BACKG_CONTROLLER_lose_In,
    input  SC_BACKG_CONTROLLER_clear_OutLow,
    input  SC_BACKG_CONTROLLER_load_OutLow,
    input  SC_BACKG_CONTROLLER_shiftselection_Out,
    input  SC_BACKG_CONTROLLER_transitioncounter_OutBUS
  );

  modport slave (
    input  SC_BACKG_CONTROLLER_start_InLow,
    input  SC_BACKG_CONTROLLER_tick_In,
    input  SC_BACKG_CONTROLLER_levelup_In,
    input  SC_BACKG_CONTROLLER_lose_In,
    output SC_BACKG_CONTROLLER_clear_OutLow,
    output SC_BACKG_CONTROLLER_load_OutLow,
    output SC_BACKG_CONTROLLER_shiftselection_Out,
    output SC_BACKG_CONTROLLER_transitioncounter_OutBUS
  );

endinterface

// File: rtl/sc_backg_tickcounter.sv
// sc_backg_tickcounter
// Counts animation ticks spent on a transition screen.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count up by one this cycle
//   term     : high while the count equals TERMINAL
module sc_backg_tickcounter #(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over enable so a LOAD cycle always restarts at 0.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == TERMINAL);

endmodule

// File: rtl/sc_backg_controller.sv
// sc_backg_controller
// Sequences the frogger background: start screen, transition screens,
// levels, lost and won screens. Commands the background register with
// clear/load strobes and a per-tick rotate selection, and publishes the
// current game stage.
//   SC_BACKG_CONTROLLER_CLOCK_50     : system clock, rising edge
//   SC_BACKG_CONTROLLER_RESET_InHigh : asynchronous active-high reset
//   bus (slave)                      : start/tick/levelup/lose in,
//                                      clear/load/shiftselection/stage out
// TRANSITION_TICKS (1..15): ticks spent on each transition screen.
module sc_backg_controller
  import sc_backg_controller_pkg::*;
#(
  parameter int TRANSITION_TICKS = 8
) (
  input  logic                  SC_BACKG_CONTROLLER_CLOCK_50,
  input  logic                  SC_BACKG_CONTROLLER_RESET_InHigh,
  sc_backg_controller_if.slave  bus
);

  logic clk;
  logic rst;
  assign clk = SC_BACKG_CONTROLLER_CLOCK_50;
  assign rst = SC_BACKG_CONTROLLER_RESET_InHigh;

  logic start_n;
  logic tick;
  logic levelup;
  logic lose;
  assign start_n = bus.SC_BACKG_CONTROLLER_start_InLow;
  assign tick    = bus.SC_BACKG_CONTROLLER_tick_In;
  assign levelup = bus.SC_BACKG_CONTROLLER_levelup_In;
  assign lose    = bus.SC_BACKG_CONTROLLER_lose_In;

  state_e          state_q;
  state_e          state_d;
  logic [TC_W-1:0] tc_q;
  logic [TC_W-1:0] tc_d;
  shift_e          shift_sel;
  logic            tk_clr;
  logic            tk_en;
  logic            tk_term;

  // The terminal count is TRANSITION_TICKS-1: the tick that would bring the
  // count to TRANSITION_TICKS ends the screen instead of incrementing.
  sc_backg_tickcounter #(
    .WIDTH    (4),
    .TERMINAL (4'(TRANSITION_TICKS - 1))
  ) u_tickcounter (
    .clk  (clk),
    .rst  (rst),
    .clr  (tk_clr),
    .en   (tk_en),
    .term (tk_term)
  );

  // Next state, next stage and the tick-aligned shift pulse. Every stage
  // change passes through LOAD, so the new stage is on the output in the
  // same cycle the load strobe is asserted.
  always_comb begin
    state_d   = state_q;
    tc_d      = tc_q;
    shift_sel = SHIFT_HOLD;
    tk_clr    = 1'b0;
    tk_en     = 1'b0;
    unique case (state_q)
      INIT: begin
        state_d = LOAD;
      end
      LOAD: begin
        tk_clr = 1'b1;
        // Stage 9 is odd, so the win check must precede the odd check.
        if (tc_q == TC_START) begin
          state_d = START;
        end else if (tc_q == TC_WIN) begin
          state_d = WON;
        end else if (tc_q[0]) begin
          state_d = TRANS;
        end else begin
          state_d = LEVEL;
        end
      end
      START: begin
        if (tick) begin
          shift_sel = SHIFT_LEFT;
        end
        if (!start_n) begin
          tc_d    = next_stage(TC_START);
          state_d = LOAD;
        end
      end
      TRANS: begin
        if (tick) begin
          shift_sel = SHIFT_RIGHT;
          if (tk_term) begin
            tc_d    = next_stage(tc_q);
            state_d = LOAD;
          end else begin
            tk_en = 1'b1;
          end
        end
      end
      LEVEL: begin
        // A collision outranks reaching the goal in the same cycle.
        if (lose) begin
          state_d = LOST;
        end else if (levelup) begin
          tc_d    = next_stage(tc_q);
          state_d = LOAD;
        end else if (tick) begin
          shift_sel = SHIFT_LEFT;
        end
      end
      LOST: begin
        if (!start_n) begin
          tc_d    = TC_START;
          state_d = LOAD;
        end
      end
      WON: begin
        if (!start_n) begin
          tc_d    = TC_START;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      tc_q    <= TC_START;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // Clear and load are decoded from mutually exclusive states, so they can
  // never be asserted together.
  assign bus.SC_BACKG_CONTROLLER_clear_OutLow             = (state_q != LOST);
  assign bus.SC_BACKG_CONTROLLER_load_OutLow              = (state_q != LOAD);
  assign bus.SC_BACKG_CONTROLLER_shiftselection_Out       = shift_sel;
  assign bus.SC_BACKG_CONTROLLER_transitioncounter_OutBUS = tc_q;

endmodule

// File: doc/sc_backg_controller.md
SC_BACKG_CONTROLLER -- requirements
Module: sc_backg_controller

Interface
REQ-001 Parameter TRANSITION_TICKS, default 8, number of tick_In pulses spent on each transition screen (legal 1..15).
REQ-002 SC_BACKG_CONTROLLER_CLOCK_50  in  1  single system clock; all state changes on its rising edge.
REQ-003 SC_BACKG_CONTROLLER_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-004 SC_BACKG_CONTROLLER_start_InLow  in  1  debounced start button, active-low level.
REQ-005 SC_BACKG_CONTROLLER_tick_In  in  1  one-cycle animation-rate pulse from the clock divider.
REQ-006 SC_BACKG_CONTROLLER_levelup_In  in  1  one-cycle pulse: frog reached goal row.
REQ-007 SC_BACKG_CONTROLLER_lose_In  in  1  one-cycle pulse: frog collision.
REQ-008 SC_BACKG_CONTROLLER_clear_OutLow  out  1  clear command to background register, active-low.
REQ-009 SC_BACKG_CONTROLLER_load_OutLow  out  1  load-pattern command to background register, active-low.
REQ-010 SC_BACKG_CONTROLLER_shiftselection_Out  out  2  00 hold, 01 rotate left, 10 rotate right; 11 never driven.
REQ-011 SC_BACKG_CONTROLLER_transitioncounter_OutBUS  out  4  game stage: 0 start, odd 1/3/5/7 transition, even 2/4/6/8 level, 9 win.

Function
REQ-012 FSM states SHALL be INIT, LOAD, START, TRANS, LEVEL, LOST, WON; transitioncounter is a 4-bit register tc, tick count a 4-bit register tk.
REQ-013 INIT SHALL go to LOAD unconditionally on the next clock.
REQ-014 LOAD SHALL last exactly one cycle, drive load_OutLow=0, clear tk, and exit to START if tc=0, TRANS if tc odd, LEVEL if tc in {2,4,6,8}, WON if tc=9.
REQ-015 START: tick_In SHALL drive shiftselection=01 that cycle; start_InLow=0 SHALL set tc=1 and go to LOAD.
REQ-016 TRANS: tick_In SHALL drive shiftselection=10 and increment tk; the tick on which tk=TRANSITION_TICKS-1 SHALL instead set tc=tc+1 and go to LOAD.
REQ-017 LEVEL: lose_In SHALL go to LOST; else levelup_In SHALL set tc=tc+1 and go to LOAD; else tick_In SHALL drive shiftselection=01.
REQ-018 Simultaneous lose_In and levelup_In in LEVEL SHALL be resolved as lose; tc unchanged.
REQ-019 LOST SHALL drive clear_OutLow=0 every cycle in state and hold tc; start_InLow=0 SHALL set tc=0 and go to LOAD.
REQ-020 WON SHALL hold tc=9 with all commands inactive; start_InLow=0 SHALL set tc=0 and go to LOAD.
REQ-021 start_InLow SHALL be ignored in LOAD, TRANS, LEVEL; tick_In, levelup_In, lose_In SHALL be ignored in INIT, LOAD, LOST, WON.
REQ-022 shiftselection SHALL be 00 in every cycle not named in REQ-015..017; it is a one-cycle pulse aligned with tick_In (combinational from state and tick_In).
REQ-023 clear_OutLow and load_OutLow SHALL never both be 0 in the same cycle; both are Moore outputs decoded from state.
REQ-024 tc SHALL never exceed 9; tc+1 is only applied from states where tc<=8.
REQ-025 Latency: event pulse at edge N -> LOAD active in cycle N+1 with new tc visible on the output in the same cycle.

Reset
REQ-026 Reset SHALL force state INIT, tc=0, tk=0 immediately and asynchronously, including mid-transition or mid-level.
REQ-027 During and directly after reset: clear_OutLow=1, load_OutLow=1, shiftselection=00, transitioncounter=0.

Structure
REQ-028 State encoding, tc constants (TC_START=0, TC_WIN=9), and shift codes (SHIFT_HOLD/LEFT/RIGHT) SHALL live in a shared package used also by the background register instance.
REQ-029 The tk counter with clear/enable/terminal-count output SHALL be a sub-module named sc_backg_tickcounter, width 4.

Verification
REQ-030 Reset release, idle 5 cycles -> LOAD one cycle (load_OutLow=0), then START, tc=0, clear_OutLow=1.
REQ-031 In START pulse start_InLow low; with TRANSITION_TICKS=8 apply 8 ticks -> 8 pulses of shiftselection=10, tc 1->2 on 8th tick, one LOAD cycle, state LEVEL.
REQ-032 In LEVEL tc=2 apply tick -> shiftselection=01 one cycle; levelup_In -> tc=3, LOAD; repeat through tc=8 levelup -> tc=9, WON, outputs inactive.
REQ-033 In LEVEL tc=4 apply lose_In and levelup_In same cycle -> LOST, clear_OutLow=0, tc stays 4; then start_InLow low -> tc=0, LOAD.
REQ-034 Assert reset 3 ticks into a transition (tc=3, tk=3) -> outputs at reset values immediately, tc=0; after release resumes at REQ-030.
REQ-035 Assertion over all runs: clear_OutLow and load_OutLow never both 0; shiftselection never 11; tc never >9.
